// File: rtl/switch_allocator.sv
// switch_allocator: per-node 5x5 switch allocator with registered output slots.
//
// Each of five inputs (N,W,S,E,B = 0..4) offers one single-flit packet and a
// route request; the lowest set request bit selects its single target output.
// Each output arbitrates independently among its requesters: high-QoS class
// first, round-robin within a class. An optional starvation guard forces a
// low-QoS grant after STARVE_LIMIT consecutive high-QoS grants with low-QoS
// traffic waiting. Winners are registered into a per-output valid/ready slot.
//
// Optional feature macro: SA_STARVE_GUARD_EN (undefined = strict HI priority).
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid[5]  input i holds a packet
//   in_req[25]   in_req[5i +: 5] = route request of input i
//   in_pkt       in_pkt[PKT_W*i +: PKT_W] = packet of input i
//   in_ready[5]  input i consumed this cycle (combinational grant)
//   out_valid[5] output slot o holds a packet
//   out_pkt      out_pkt[PKT_W*o +: PKT_W] = packet in slot o
//   out_src[15]  out_src[3o +: 3] = input that supplied slot o
//   out_ready[5] downstream accepts slot o this cycle
module switch_allocator #(
    parameter int unsigned PKT_W        = 23,
    parameter int unsigned QOS_POS      = 20,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           in_valid,
    input  logic [24:0]          in_req,
    input  logic [5*PKT_W-1:0]   in_pkt,
    output logic [4:0]           in_ready,
    output logic [4:0]           out_valid,
    output logic [5*PKT_W-1:0]   out_pkt,
    output logic [14:0]          out_src,
    input  logic [4:0]           out_ready
);

    localparam int unsigned N_PORTS = 5;
    localparam int unsigned SRC_W   = 3;

    logic [N_PORTS-1:0][N_PORTS-1:0] req_sel;   // [input][output]
    logic [N_PORTS-1:0][N_PORTS-1:0] col;       // [output][input]
    logic [N_PORTS-1:0]              qos;
    logic [N_PORTS-1:0][N_PORTS-1:0] hi_mask;
    logic [N_PORTS-1:0][N_PORTS-1:0] lo_mask;
    logic [N_PORTS-1:0][3:0]         pick;
    logic [N_PORTS-1:0][N_PORTS-1:0] grant;     // [output][input]
    logic [N_PORTS-1:0]              grant_any;
    logic [N_PORTS-1:0][SRC_W-1:0]   win_idx;
    logic [N_PORTS-1:0][PKT_W-1:0]   win_pkt;
    logic [N_PORTS-1:0]              win_hi;
    logic [N_PORTS-1:0]              lo_any;
    logic [N_PORTS-1:0]              slot_free;
    logic [N_PORTS-1:0]              forced_low;
    logic [N_PORTS-1:0]              ready_c;
    logic [N_PORTS-1:0][SRC_W-1:0]   rr_ptr;

    // Isolate the lowest set bit of a request vector.
    function automatic logic [4:0] lowest_bit(input logic [4:0] r);
        return r & (~r + 5'd1);
    endfunction

    // First set bit of mask at or after ptr, cyclically; returns {found, idx}.
    function automatic logic [3:0] pick_rr(input logic [4:0] mask, input logic [2:0] ptr);
        logic [3:0] res;
        logic [3:0] sum;
        logic [2:0] idx;
        res = '0;
        for (int unsigned k = 0; k < 5; k++) begin
            sum = 4'(ptr) + 4'(k);
            idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : 3'(sum);
            if (!res[3] && mask[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign slot_free = ~out_valid | out_ready;

    // Request decode: one target output per valid input, QoS flag per input.
    always_comb begin
        req_sel = '0;
        col     = '0;
        qos     = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            qos[i] = in_pkt[PKT_W*i + QOS_POS];
            if (in_valid[i]) req_sel[i] = lowest_bit(in_req[5*i +: 5]);
        end
        for (int unsigned o = 0; o < N_PORTS; o++)
            for (int unsigned i = 0; i < N_PORTS; i++)
                col[o][i] = req_sel[i][o];
    end

    // Per-output class selection and round-robin pick.
    // Forced-low only overrides HI when a LO requester exists, so a lapsed
    // LO request can never stall the output with the counter at its limit.
    always_comb begin
        hi_mask = '0;
        lo_mask = '0;
        pick    = '0;
        grant   = '0;
        win_idx = '0;
        win_pkt = '0;
        win_hi  = '0;
        lo_any  = '0;
        for (int unsigned o = 0; o < N_PORTS; o++) begin
            hi_mask[o] = col[o] & qos;
            lo_mask[o] = col[o] & ~qos;
            lo_any[o]  = |lo_mask[o];
            win_hi[o]  = (|hi_mask[o]) && !(forced_low[o] && lo_any[o]);
            pick[o]    = pick_rr(win_hi[o] ? hi_mask[o] : lo_mask[o], rr_ptr[o]);
            win_idx[o] = pick[o][2:0];
            if (slot_free[o] && pick[o][3]) grant[o] = 5'd1 << pick[o][2:0];
            for (int unsigned i = 0; i < N_PORTS; i++)
                if (grant[o][i]) win_pkt[o] = in_pkt[PKT_W*i +: PKT_W];
        end
    end

    // Combine per-output grants into per-input ready.
    always_comb begin
        ready_c   = '0;
        grant_any = '0;
        for (int unsigned o = 0; o < N_PORTS; o++) begin
            ready_c      = ready_c | grant[o];
            grant_any[o] = |grant[o];
        end
    end

    assign in_ready = rst_n ? ready_c : '0;

    // Output slots and round-robin pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            out_pkt   <= '0;
            out_src   <= '0;
            rr_ptr    <= '0;
        end else begin
            for (int unsigned o = 0; o < N_PORTS; o++) begin
                if (grant_any[o]) begin
                    out_valid[o]               <= 1'b1;
                    out_pkt[PKT_W*o +: PKT_W]  <= win_pkt[o];
                    out_src[SRC_W*o +: SRC_W]  <= win_idx[o];
                    rr_ptr[o] <= (win_idx[o] == 3'd4) ? 3'd0 : 3'(win_idx[o] + 3'd1);
                end else if (out_ready[o]) begin
                    out_valid[o] <= 1'b0;
                end
            end
        end
    end

`ifdef SA_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [N_PORTS-1:0][3:0] starve_cnt;

    // Count HI grants made over waiting LO traffic; any other grant clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else begin
            for (int unsigned o = 0; o < N_PORTS; o++) begin
                if (grant_any[o]) begin
                    if (win_hi[o] && lo_any[o])
                        starve_cnt[o] <= (starve_cnt[o] >= LIMIT) ? LIMIT : 4'(starve_cnt[o] + 4'd1);
                    else
                        starve_cnt[o] <= '0;
                end
            end
        end
    end

    always_comb begin
        forced_low = '0;
        for (int unsigned o = 0; o < N_PORTS; o++)
            forced_low[o] = (starve_cnt[o] == LIMIT);
    end
`else
    logic unused_guard;

    assign forced_low   = '0;
    assign unused_guard = ^{32'(STARVE_LIMIT), win_hi};
`endif

endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Per-node 5x5 switch allocator and output register stage. It sits between the five per-input route_req generators and the five node output links (N, W, S, E, B).
- Each input presents one single-flit packet plus a one-hot output request. Per output, the block arbitrates among requesters by QoS class, then round-robin, with a starvation guard for low-QoS traffic.
- The winning packet is registered into that output's slot, which holds it under a valid/ready handshake.

Parameters:
- PKT_W, 23, packet width in bits.
- QOS_POS, 20, bit index of the QoS flag inside a packet.
- STARVE_LIMIT, 4, consecutive high-QoS grants on one output, with a low-QoS requester waiting, before low-QoS is forced (range 1-15).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  5  input i holds a packet; index order [N,W,S,E,B] = 0..4.
- in_req  in  25  in_req[5i+4:5i] = route request of input i, bit o = output o.
- in_pkt  in  5*PKT_W  in_pkt[PKT_W*i +: PKT_W] = packet of input i.
- in_ready  out  5  input i packet consumed this cycle (combinational grant).
- out_valid  out  5  output slot o holds a packet.
- out_pkt  out  5*PKT_W  packet held in slot o.
- out_src  out  15  out_src[3o+2:3o] = input index that supplied slot o.
- out_ready  in  5  downstream accepts slot o this cycle.

Behaviour:
- Reset (async assert, sync release):
  - out_valid, out_pkt, out_src = 0.
  - All round-robin pointers and starve counters = 0.
  - in_ready = 0 while rst_n is low.
- Effective request of input i:
  - in_valid[i] and the lowest set bit of in_req[i].
  - in_req[i] == 0: no request, and in_ready[i] stays 0.
  - Because each input targets at most one output, no input can win two outputs.
- Slot o is free when !out_valid[o] || out_ready[o]. This allows a same-cycle drain and reload, giving 1 packet/cycle per output.
- Arbitration per output o, only when slot o is free:
  - HI = requesters with pkt[QOS_POS]=1; LO = the rest.
  - Class selection:
    - If HI is non-empty and not forced-low, choose from HI.
    - Otherwise choose from LO.
  - Within the chosen class, pick the first requester at or after rr_ptr[o], cyclically 0..4.
- On grant to input i, in_ready[i] = 1 (combinational, same cycle). At the next edge:
  - out_pkt[o] <= in_pkt[i], out_src[o] <= i, out_valid[o] <= 1.
  - rr_ptr[o] <= (i==4) ? 0 : i+1.
- No grant while the slot is free:
  - If out_ready[o]=1, out_valid[o] <= 0.
  - rr_ptr[o] and starve_cnt[o] are unchanged.
- Slot occupied and out_ready[o]=0: slot contents, out_valid and rr_ptr are held, and no input targeting o gets in_ready.
- Latency: accepted input to out_valid = 1 cycle.
- Starvation guard, 4-bit starve_cnt[o]:
  - Increments on each HI grant while LO is non-empty, saturating at STARVE_LIMIT.
  - Resets to 0 on any LO grant, or when LO is empty at a grant.
  - forced-low = (starve_cnt[o] == STARVE_LIMIT).
- Outputs are independent: up to 5 grants per cycle.
- Packets are passed unmodified, and out_pkt is only updated on a grant.

Optional Feature:
- SA_STARVE_GUARD_EN
- Defined: the starvation guard above is present.
- Undefined: starve_cnt logic is removed, forced-low is constant 0, HI has strict priority over LO, and STARVE_LIMIT is ignored.
- All other behaviour is identical in both builds.

Test Plan:
1. Reset mid-traffic: assert rst_n=0 with out_valid=5'b11111 -> out_valid, out_pkt, out_src are 0 immediately, and in_ready=0 while rst_n is low.
2. Single path: input W (1) has valid, in_req=5'b01000 (E), qos=0, pkt=23'h012345, out_ready=all 1 -> in_ready=5'b00010 that cycle, then the next cycle out_valid[3]=1, out_pkt slot 3 = 23'h012345, out_src[11:9]=1.
3. Round-robin: inputs 0, 2 and 4 all request B continuously with qos=0 and out_ready[4]=1 -> grant order 0, 2, 4, 0, 2, one per cycle.
4. Backpressure: slot E occupied and out_ready[3]=0 for 3 cycles with input N requesting E -> in_ready[0]=0 and the slot is held. Raise out_ready[3] -> same-cycle grant to N, with no bubble.
5. QoS with guard defined, STARVE_LIMIT=4: input 1 qos=1 and input 2 qos=0 both request S continuously -> grants 1, 1, 1, 1, 2, 1, 1, 1, 1, 2, ...
6. Guard undefined, same stimulus -> input 2 is never granted while input 1 requests. Drop input 1 -> input 2 is granted the next cycle.
